// File: rtl/sap3_pkg.sv
// Shared types and default widths for the sap3 clock controller.
// Holds the run/halt/step state encoding and width defaults.
package sap3_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   localparam int STEP_W_DEF = 8;
   localparam int CYC_W_DEF  = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached; only i_clr brings it back to zero.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;
   logic         w_full;

   assign w_full = (r_cnt == {W{1'b1}});

   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !w_full) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/clock_ctrl.sv
// Run/halt/step controller producing a registered hlt level for the core clock gate.
// Step bursts exist only when CLOCK_CTRL_STEP_EN is defined.
module clock_ctrl
   import sap3_pkg::*;
#(
   parameter bit START_RUN = 1'b1,
   parameter int STEP_W    = STEP_W_DEF,
   parameter int CYC_W     = CYC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hlt_instr,
   input  logic              halt_req,
   input  logic              run_req,
   input  logic              step_req,
   input  logic [STEP_W-1:0] step_count,
   output logic              hlt,
   output logic              step_done,
   output logic [CYC_W-1:0]  cyc_cnt
);

   localparam state_t RST_ST = START_RUN ? ST_RUN : ST_HALT;

   state_t r_state;
   state_t w_state;
   logic   r_hlt;
   logic   r_hlt_prev;
   logic   w_edge;
   logic   w_stop;

   assign w_edge = hlt_instr & ~r_hlt_prev;
   assign w_stop = halt_req | w_edge;

`ifdef CLOCK_CTRL_STEP_EN
   logic [STEP_W-1:0] r_cnt;
   logic [STEP_W-1:0] w_cnt;
   logic              r_done;
   logic              w_done;
`else
   logic w_unused_step;
   assign w_unused_step = step_req | (|step_count);
`endif

   always_comb begin
      w_state = r_state;
`ifdef CLOCK_CTRL_STEP_EN
      w_cnt  = r_cnt;
      w_done = 1'b0;
`endif
      unique case (r_state)
         ST_RUN: begin
            if (w_stop) w_state = ST_HALT;
         end
         ST_HALT: begin
            if (w_stop) begin
               w_state = ST_HALT;
            end else if (run_req) begin
               w_state = ST_RUN;
            end
`ifdef CLOCK_CTRL_STEP_EN
            else if (step_req) begin
               if (step_count != '0) begin
                  w_state = ST_STEP;
                  w_cnt   = step_count;
               end else begin
                  w_done = 1'b1;
               end
            end
`endif
         end
`ifdef CLOCK_CTRL_STEP_EN
         ST_STEP: begin
            w_cnt = r_cnt - STEP_W'(1);
            // an abort wins over a burst that would end this same cycle
            if (w_stop) begin
               w_state = ST_HALT;
            end else if (r_cnt == STEP_W'(1)) begin
               w_state = ST_HALT;
               w_done  = 1'b1;
            end
         end
`endif
         default: w_state = ST_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= RST_ST;
         r_hlt      <= ~START_RUN;
         r_hlt_prev <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_hlt      <= (w_state == ST_HALT);
         r_hlt_prev <= hlt_instr;
      end
   end

`ifdef CLOCK_CTRL_STEP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_cnt  <= w_cnt;
         r_done <= w_done;
      end
   end

   assign step_done = r_done;
`else
   assign step_done = 1'b0;
`endif

   sat_counter #(
      .W (CYC_W)
   ) u_cyc (
      .clk   (clk),
      .i_clr (rst),
      .i_en  (~r_hlt),
      .o_cnt (cyc_cnt)
   );

   assign hlt = r_hlt;

endmodule
